// File: rtl/rc_tdc_pkg.sv
// Shared types and constants for the RC time-to-digital result path.
// Holds the FSM state encoding and default widths/divisor.
package rc_tdc_pkg;

  localparam int unsigned CNT_W_DEF   = 24;
  localparam int unsigned RES_W       = 8;
  localparam int unsigned DIVISOR_DEF = 69;

  localparam logic [RES_W-1:0] RES_SAT_CODE = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StSat,
    StDone
  } rc_state_e;

endpackage

// File: rtl/rc_seq_divider.sv
// Restoring divider by a constant, one quotient bit per step, MSB first.
// o_quot_next is the quotient including the bit resolved in the current step.
module rc_seq_divider #(
  parameter int unsigned DIVISOR = 69,
  parameter int unsigned CNT_W   = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [CNT_W-1:0] i_dividend,
  output logic [CNT_W-1:0] o_quot_next,
  output logic             o_last
);

  localparam int unsigned RemW = CNT_W + 1;
  localparam int unsigned BitW = $clog2(CNT_W);
  localparam logic [RemW:0] DivisorW = (RemW + 1)'(DIVISOR);

  logic [CNT_W-1:0] r_dividend;
  logic [CNT_W-1:0] r_quot;
  logic [RemW-1:0]  r_rem;
  logic [BitW-1:0]  r_bitcnt;

  logic [RemW:0]    w_rem_shift;
  logic [RemW:0]    w_rem_sub;
  logic [RemW-1:0]  w_rem_next;
  logic             w_qbit;

  // Bits are consumed/placed by index rather than shifted, so no register bit goes unused.
  always_comb begin
    w_rem_shift = {r_rem, r_dividend[r_bitcnt]};
    w_qbit      = (w_rem_shift >= DivisorW);
    w_rem_sub   = w_rem_shift - DivisorW;
    w_rem_next  = w_qbit ? RemW'(w_rem_sub) : RemW'(w_rem_shift);
    o_quot_next = r_quot | (CNT_W'(w_qbit) << r_bitcnt);
    o_last      = (r_bitcnt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dividend <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_bitcnt   <= '0;
    end else if (i_start) begin
      r_dividend <= i_dividend;
      r_quot     <= '0;
      r_rem      <= '0;
      r_bitcnt   <= BitW'(CNT_W - 1);
    end else if (i_step) begin
      r_quot     <= o_quot_next;
      r_rem      <= w_rem_next;
      r_bitcnt   <= r_bitcnt - 1'b1;
    end
  end

endmodule

// File: rtl/rc_result_calc.sv
// Converts a raw RC-discharge timer count into an 8-bit resistance code.
// Handles the valid/ready handshakes, overflow bypass and saturation.
module rc_result_calc
  import rc_tdc_pkg::*;
#(
  parameter int unsigned DIVISOR = DIVISOR_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_in,
  input  logic             count_valid,
  input  logic             overflow_in,
  output logic             count_ready,
  output logic [RES_W-1:0] res_out,
  output logic             res_valid,
  output logic             res_sat,
  input  logic             res_ready,
  output logic             busy
);

  if (DIVISOR == 0) begin : g_bad_divisor
    $error("rc_result_calc: DIVISOR must be non-zero");
  end

  rc_state_e        r_state;
  rc_state_e        w_state_d;
  logic [RES_W-1:0] r_res_out;
  logic [RES_W-1:0] w_res_out_d;
  logic             r_res_sat;
  logic             w_res_sat_d;
  logic             w_start;
  logic             w_step;
  logic             w_last;
  logic             w_accept;
  logic             w_quot_ovf;
  logic [CNT_W-1:0] w_quot_next;

  rc_seq_divider #(
    .DIVISOR (DIVISOR),
    .CNT_W   (CNT_W)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_start),
    .i_step      (w_step),
    .i_dividend  (count_in),
    .o_quot_next (w_quot_next),
    .o_last      (w_last)
  );

  assign w_quot_ovf = |w_quot_next[CNT_W-1:RES_W];
  assign w_accept   = count_valid && count_ready;

  always_comb begin
    w_state_d   = r_state;
    w_res_out_d = r_res_out;
    w_res_sat_d = r_res_sat;
    w_start     = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (overflow_in) begin
            w_state_d = StSat;
          end else begin
            w_start   = 1'b1;
            w_state_d = StDiv;
          end
        end
      end
      StDiv: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_d = StDone;
          if (w_quot_ovf) begin
            w_res_out_d = RES_SAT_CODE;
            w_res_sat_d = 1'b1;
          end else begin
            w_res_out_d = w_quot_next[RES_W-1:0];
            w_res_sat_d = 1'b0;
          end
        end
      end
      StSat: begin
        w_res_out_d = RES_SAT_CODE;
        w_res_sat_d = 1'b1;
        w_state_d   = StDone;
      end
      StDone: begin
        if (res_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_res_out <= '0;
      r_res_sat <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_res_out <= w_res_out_d;
      r_res_sat <= w_res_sat_d;
    end
  end

  // Gate with reset so no count is offered while the block is held.
  assign count_ready = (r_state == StIdle) && !reset;
  assign res_valid   = (r_state == StDone);
  assign busy        = (r_state != StIdle);
  assign res_out     = r_res_out;
  assign res_sat     = r_res_sat;

endmodule

// File: tb/tb_rc_result_calc.sv
// Directed self-checking bench for rc_result_calc with hand-computed results.
module tb_rc_result_calc;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] count_in;
  logic        count_valid;
  logic        overflow_in;
  logic        count_ready;
  logic [7:0]  res_out;
  logic        res_valid;
  logic        res_sat;
  logic        res_ready;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rc_result_calc #(
    .DIVISOR (69),
    .CNT_W   (24)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .count_valid (count_valid),
    .overflow_in (overflow_in),
    .count_ready (count_ready),
    .res_out     (res_out),
    .res_valid   (res_valid),
    .res_sat     (res_sat),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One transaction from IDLE; count_valid stays high with a different count while busy.
  task automatic run(input string tag, input logic [23:0] cnt, input logic ovf, input int exp_lat,
                     input logic [7:0] exp_out, input logic exp_sat, input int hold);
    int edges;
    count_in    = cnt;
    overflow_in = ovf;
    count_valid = 1'b1;
    res_ready   = 1'b0;
    check({tag, ".ready"}, 32'(count_ready), 32'd1);
    @(posedge clk); #1;
    edges       = 1;
    count_in    = 24'd69;
    overflow_in = 1'b0;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    while (!res_valid && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, ".latency"}, 32'(edges), 32'(exp_lat));
    check({tag, ".out"}, 32'(res_out), 32'(exp_out));
    check({tag, ".sat"}, 32'(res_sat), 32'(exp_sat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(res_valid), 32'd1);
      check({tag, ".hold_out"}, 32'(res_out), 32'(exp_out));
      check({tag, ".hold_sat"}, 32'(res_sat), 32'(exp_sat));
      check({tag, ".hold_ready"}, 32'(count_ready), 32'd0);
    end
    count_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk); #1;
    check({tag, ".released"}, 32'(res_valid), 32'd0);
    check({tag, ".idle"}, 32'(count_ready), 32'd1);
    res_ready = 1'b0;
  endtask

  initial begin
    logic [23:0] vals [3];
    logic [7:0]  results [4];
    int          idx;
    int          nres;
    logic        acc;
    logic        take;

    reset       = 1'b1;
    count_in    = '0;
    count_valid = 1'b0;
    overflow_in = 1'b0;
    res_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 32'(count_ready), 32'd0);
    check("rst.out", 32'(res_out), 32'd0);
    check("rst.valid", 32'(res_valid), 32'd0);
    check("rst.sat", 32'(res_sat), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    check("rst.ready_after", 32'(count_ready), 32'd1);
    @(posedge clk); #1;

    run("c6900", 24'd6900, 1'b0, 25, 8'd100, 1'b0, 0);
    run("c0", 24'd0, 1'b0, 25, 8'd0, 1'b0, 0);
    run("c17663", 24'd17663, 1'b0, 25, 8'd255, 1'b0, 0);
    run("c17664", 24'd17664, 1'b0, 25, 8'hFF, 1'b1, 0);
    run("ovf", 24'd6900, 1'b1, 2, 8'hFF, 1'b1, 0);
    run("cmax_hold", 24'hFFFFFF, 1'b0, 25, 8'hFF, 1'b1, 10);
    run("after_hold", 24'd138, 1'b0, 25, 8'd2, 1'b0, 0);

    // Asynchronous reset in the middle of a division; res_out still holds 2 here.
    count_in    = 24'd6900;
    count_valid = 1'b1;
    @(posedge clk); #1;
    count_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst.out", 32'(res_out), 32'd0);
    check("midrst.valid", 32'(res_valid), 32'd0);
    check("midrst.sat", 32'(res_sat), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.ready", 32'(count_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst.ready_after", 32'(count_ready), 32'd1);
    run("c690", 24'd690, 1'b0, 25, 8'd10, 1'b0, 0);

    // Back-to-back counts with count_valid never dropped between them.
    vals[0]     = 24'd69;
    vals[1]     = 24'd138;
    vals[2]     = 24'd207;
    idx         = 0;
    nres        = 0;
    count_in    = vals[0];
    count_valid = 1'b1;
    res_ready   = 1'b1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      acc  = count_ready && count_valid;
      take = res_valid && res_ready;
      if (take) begin
        if (nres < 4) results[nres] = res_out;
        nres++;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) count_in = vals[idx];
        else count_valid = 1'b0;
      end
    end
    check("b2b.accepts", 32'(idx), 32'd3);
    check("b2b.results", 32'(nres), 32'd3);
    check("b2b.r0", 32'(results[0]), 32'd1);
    check("b2b.r1", 32'(results[1]), 32'd2);
    check("b2b.r2", 32'(results[2]), 32'd3);
    res_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rc_result_calc.md
RC_RESULT_CALC -- requirements
Module: rc_result_calc

Interface
REQ-001 SHALL have parameter DIVISOR, default 69, meaning the divisor in count units (C*ln2 for C=100 pF, rounded); DIVISOR=0 SHALL be rejected at elaboration.
REQ-002 SHALL have parameter CNT_W, default 24, meaning the raw count width.
REQ-003 SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port count_in, input, CNT_W bits: the raw timer count to convert.
REQ-006 SHALL have port count_valid, input, 1 bit: count_in and overflow_in are valid this cycle.
REQ-007 SHALL have port overflow_in, input, 1 bit: the timer wrapped, so the count is meaningless.
REQ-008 SHALL have port count_ready, output, 1 bit: the block accepts a new count this cycle.
REQ-009 SHALL have port res_out, output, 8 bits: the resistance code.
REQ-010 SHALL have port res_valid, output, 1 bit: res_out and res_sat are valid.
REQ-011 SHALL have port res_sat, output, 1 bit: the result saturated or came from an overflow.
REQ-012 SHALL have port res_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, DIV, SAT and DONE.
REQ-015 SHALL drive count_ready high only in IDLE; accept = count_valid && count_ready at a rising edge.
REQ-016 IDLE, on accept with overflow_in=0: SHALL capture count_in as the dividend, clear the remainder, load the bit counter with CNT_W-1, and go to DIV.
REQ-017 IDLE, on accept with overflow_in=1: SHALL go to SAT; count_in is ignored.
REQ-018 DIV SHALL run a restoring division, MSB first, one quotient bit per cycle:
- rem = {rem, next dividend bit}
- if rem >= DIVISOR, subtract DIVISOR and set the quotient bit.
REQ-019 DIV SHALL last exactly CNT_W cycles, then go to DONE.
REQ-020 On the DIV-to-DONE edge, the output register SHALL be loaded:
- quotient > 255: res_out=8'hFF, res_sat=1
- otherwise: res_out = quotient[7:0], res_sat=0.
REQ-021 SAT SHALL load res_out=8'hFF and res_sat=1 on its single cycle, then go to DONE.
REQ-022 Latency SHALL be:
- 25 clk edges from the accept edge to res_valid high for the normal path;
- 2 clk edges for the overflow path.
REQ-023 DONE SHALL hold res_valid=1 and keep res_out/res_sat stable until res_ready=1 at an edge, then return to IDLE with res_valid=0.
REQ-024 count_valid asserted while not in IDLE SHALL be ignored and SHALL NOT disturb an operation in progress.
REQ-025 A new count SHALL NOT be accepted on the same edge that DONE is left; the earliest next accept is the following edge.
REQ-026 res_out and res_sat SHALL be registered outputs, with no combinational path from any input.
REQ-027 The remainder register SHALL be CNT_W+1 bits wide so the compare cannot overflow for any DIVISOR below 2^CNT_W.

Reset
REQ-028 On reset SHALL force, asynchronously and at any time including mid-DIV or in DONE:
- state=IDLE
- res_out=0, res_valid=0, res_sat=0, busy=0
- dividend, remainder and quotient cleared.
REQ-029 While reset is held, count_ready SHALL be 0; after release, count_ready SHALL be 1 from the first cycle.

Structure
REQ-030 Shared package rc_tdc_pkg SHALL hold:
- the state enum
- CNT_W_DEF=24
- RES_W=8
- DIVISOR_DEF=69
- RES_SAT_CODE=8'hFF.
REQ-031 The iterative divider datapath SHALL be one sub-module, rc_seq_divider; FSM, handshake and saturation logic SHALL stay in rc_result_calc.

Verification
REQ-032 count_in=6900, overflow_in=0, res_ready=1 -> res_valid high 25 edges after accept, res_out=100, res_sat=0.
REQ-033 count_in=0 -> res_out=0, res_sat=0; count_in=17663 -> res_out=255, res_sat=0; count_in=17664 -> res_out=8'hFF, res_sat=1.
REQ-034 overflow_in=1 with any count_in -> res_valid 2 edges after accept, res_out=8'hFF, res_sat=1.
REQ-035 count_in=24'hFFFFFF with res_ready=0 for 10 cycles -> res_valid held high, res_out=8'hFF and res_sat=1 stable, count_ready=0; releasing res_ready -> IDLE, then the next count is accepted.
REQ-036 Pulse reset at DIV cycle 12 of count_in=6900 -> all outputs 0 immediately; a fresh count_in=690 afterwards -> res_out=10.
REQ-037 count_valid held high throughout with back-to-back counts 69, 138, 207 -> exactly three results 1, 2, 3 in order, with none dropped or duplicated.
